// File: rtl/add_rr_sched.sv
// Round-robin scheduler sharing one single-cycle 32-bit adder among NREQ requesters.
// Define ADD_SCHED_PERF_EN to add the perf_ops issued-operation counter port.
module add_rr_sched #(
    parameter int NREQ = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_vld,
    input  logic [NREQ-1:0]      rsp_rdy,
    output logic [32*NREQ-1:0]   rsp_data,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_ce,
    input  logic [31:0]          add_c,
    input  logic                 add_c_vld
`ifdef ADD_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_ops
`endif
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]            r_inflight;
    logic [NREQ-1:0]            r_rsp_vld;
    logic [NREQ-1:0][31:0]      r_rsp_data;
    logic [IW-1:0]              r_tag;
    logic [IW-1:0]              r_last;

    logic [NREQ-1:0]            w_elig;
    logic                       w_gnt_vld;
    logic [IW-1:0]              w_gnt_idx;
    logic                       w_load;

    // A slot being drained this cycle may be refilled by a fresh issue.
    assign w_elig = req_vld & ~r_inflight & (~r_rsp_vld | rsp_rdy);
    // Results with nothing outstanding are dropped.
    assign w_load = add_c_vld & r_inflight[r_tag];

    // Round-robin search from last+1; descending k leaves the nearest eligible index.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (w_elig[IW'((int'(r_last) + k) % NREQ)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IW'((int'(r_last) + k) % NREQ);
            end else begin
                w_gnt_vld = w_gnt_vld;
            end
        end
        if (ap_rst) begin
            w_gnt_vld = 1'b0;
        end else begin
            w_gnt_vld = w_gnt_vld;
        end
    end

    // Grant drives the handshake and the adder operands in the same cycle.
    always_comb begin
        req_rdy = '0;
        add_ce  = 1'b0;
        add_a   = 32'd0;
        add_b   = 32'd0;
        if (w_gnt_vld) begin
            req_rdy[w_gnt_idx] = 1'b1;
            add_ce             = 1'b1;
            add_a              = req_a[32*w_gnt_idx +: 32];
            add_b              = req_b[32*w_gnt_idx +: 32];
        end else begin
            add_ce = 1'b0;
        end
    end

    // Issue bookkeeping, result routing by tag, and slot drain.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_inflight <= '0;
            r_rsp_vld  <= '0;
            r_rsp_data <= '0;
            r_tag      <= '0;
            r_last     <= IW'(NREQ - 1);
        end else begin
            if (w_gnt_vld) begin
                r_tag  <= w_gnt_idx;
                r_last <= w_gnt_idx;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt_vld && (w_gnt_idx == IW'(i))) begin
                    r_inflight[i] <= 1'b1;
                end else if (w_load && (r_tag == IW'(i))) begin
                    r_inflight[i] <= 1'b0;
                end
                if (w_load && (r_tag == IW'(i))) begin
                    r_rsp_vld[i]  <= 1'b1;
                    r_rsp_data[i] <= add_c;
                end else if (r_rsp_vld[i] && rsp_rdy[i]) begin
                    r_rsp_vld[i]  <= 1'b0;
                end
            end
        end
    end

    assign rsp_vld  = r_rsp_vld;
    assign rsp_data = r_rsp_data;

`ifdef ADD_SCHED_PERF_EN
    logic [31:0] r_perf_ops;

    // Free-running issue counter; wraps naturally.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_perf_ops <= 32'd0;
        end else if (add_ce) begin
            r_perf_ops <= r_perf_ops + 32'd1;
        end
    end

    assign perf_ops = r_perf_ops;
`endif

    add_rr_sched_chk u_chk (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .load      (w_load),
        .slot_full (r_rsp_vld[r_tag])
    );

endmodule

// A returning result must never land on a slot that still holds data.
module add_rr_sched_chk (
    input logic clk,
    input logic rst,
    input logic load,
    input logic slot_full
);

    a_no_overwrite: assert property (@(posedge clk) disable iff (rst) !(load && slot_full));

endmodule

// File: tb/tb_add_rr_sched.sv
// Directed self-checking bench for add_rr_sched (NREQ=4) with a one-cycle adder model.
module tb_add_rr_sched;

    logic          ap_clk;
    logic          ap_rst;
    logic [3:0]    req_vld;
    logic [3:0]    req_rdy;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [3:0]    rsp_vld;
    logic [3:0]    rsp_rdy;
    logic [127:0]  rsp_data;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic          add_ce;
    logic [31:0]   add_c;
    logic          add_c_vld;
`ifdef ADD_SCHED_PERF_EN
    logic [31:0]   perf_ops;
`endif

    int n_checks = 0;
    int n_errors = 0;

    add_rr_sched #(.NREQ(4)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_data  (rsp_data),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ce    (add_ce),
        .add_c     (add_c),
        .add_c_vld (add_c_vld)
`ifdef ADD_SCHED_PERF_EN
        ,
        .perf_ops  (perf_ops)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Shared adder: result one cycle after ap_ce, cleared by the same reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            add_c_vld <= 1'b0;
            add_c     <= 32'd0;
        end else begin
            add_c_vld <= add_ce;
            add_c     <= add_a + add_b;
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge ap_clk);
    endtask

    task automatic do_reset();
        ap_rst  = 1'b1;
        req_vld = 4'b0000;
        rsp_rdy = 4'b0000;
        tick();
        ap_rst  = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst  = 1'b1;
        req_vld = 4'b1111;
        rsp_rdy = 4'b0000;
        req_a   = {4{32'h1234_5678}};
        req_b   = {4{32'h0000_0001}};
        tick();
        tick();
        mid();
        n_checks++;
        if (req_rdy !== 4'b0000) begin n_errors++; $display("FAIL reset_req_rdy: got %b want 0000", req_rdy); end
        n_checks++;
        if (add_ce !== 1'b0 || add_a !== 32'd0 || add_b !== 32'd0) begin
            n_errors++; $display("FAIL reset_adder: ce=%b a=%h b=%h want 0/0/0", add_ce, add_a, add_b);
        end
        n_checks++;
        if (rsp_vld !== 4'b0000 || rsp_data !== 128'd0) begin
            n_errors++; $display("FAIL reset_rsp: vld=%b data=%h want 0/0", rsp_vld, rsp_data);
        end
        tick();
        ap_rst  = 1'b0;
        req_vld = 4'b0000;
        req_a   = 128'd0;
        req_b   = 128'd0;
    endtask

    task automatic test_single_op();
        req_vld     = 4'b0001;
        req_a[31:0] = 32'd5;
        req_b[31:0] = 32'd7;
        mid();
        n_checks++;
        if (req_rdy !== 4'b0001 || add_ce !== 1'b1) begin
            n_errors++; $display("FAIL single_grant: rdy=%b ce=%b want 0001/1", req_rdy, add_ce);
        end
        n_checks++;
        if (add_a !== 32'd5 || add_b !== 32'd7) begin
            n_errors++; $display("FAIL single_operands: a=%0d b=%0d want 5/7", add_a, add_b);
        end
        tick();
        req_vld = 4'b0000;
        mid();
        n_checks++;
        if (rsp_vld !== 4'b0000) begin n_errors++; $display("FAIL single_early: rsp_vld=%b want 0000", rsp_vld); end
        tick();
        mid();
        n_checks++;
        if (rsp_vld !== 4'b0001 || rsp_data[31:0] !== 32'd12) begin
            n_errors++; $display("FAIL single_result: vld=%b data=%0d want 0001/12", rsp_vld, rsp_data[31:0]);
        end
        tick();
        rsp_rdy = 4'b0001;
        tick();
        rsp_rdy = 4'b0000;
        mid();
        n_checks++;
        if (rsp_vld !== 4'b0000 || rsp_data[31:0] !== 32'd12) begin
            n_errors++; $display("FAIL single_drain: vld=%b data=%0d want 0000/12", rsp_vld, rsp_data[31:0]);
        end
        tick();
    endtask

    task automatic test_wrap();
        req_vld     = 4'b0001;
        req_a[31:0] = 32'hFFFF_FFFF;
        req_b[31:0] = 32'd2;
        tick();
        req_vld = 4'b0000;
        tick();
        mid();
        n_checks++;
        if (rsp_vld[0] !== 1'b1 || rsp_data[31:0] !== 32'd1) begin
            n_errors++; $display("FAIL wrap_sum: vld=%b data=%h want 1/00000001", rsp_vld[0], rsp_data[31:0]);
        end
        tick();
        rsp_rdy = 4'b1111;
        tick();
        rsp_rdy = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int         s;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = i;
            req_b[32*i +: 32] = 32'd100;
        end
        req_vld = 4'b1111;
        rsp_rdy = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            mid();
            exp_rdy = 4'b0001 << (k % 4);
            n_checks++;
            if (req_rdy !== exp_rdy || add_ce !== 1'b1) begin
                n_errors++; $display("FAIL rr_grant[%0d]: rdy=%b ce=%b want %b/1", k, req_rdy, add_ce, exp_rdy);
            end
            if (k >= 2) begin
                s = (k - 2) % 4;
                n_checks++;
                if (rsp_vld[s] !== 1'b1 || rsp_data[32*s +: 32] !== 32'd100 + 32'(s)) begin
                    n_errors++;
                    $display("FAIL rr_result[%0d]: slot%0d vld=%b data=%0d want 1/%0d", k, s, rsp_vld[s], rsp_data[32*s +: 32], 100 + s);
                end
            end
            tick();
        end
        req_vld = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_a[63:32] = 32'd1;
        req_b[63:32] = 32'd1;
        req_a[95:64] = 32'd40;
        req_b[95:64] = 32'd2;
        req_vld = 4'b0010;
        mid();
        n_checks++;
        if (req_rdy !== 4'b0010) begin n_errors++; $display("FAIL bp_fill: rdy=%b want 0010", req_rdy); end
        tick();
        req_vld = 4'b0000;
        tick();
        req_vld = 4'b0110;
        mid();
        n_checks++;
        if (req_rdy !== 4'b0100 || rsp_vld !== 4'b0010) begin
            n_errors++; $display("FAIL bp_skip: rdy=%b rsp_vld=%b want 0100/0010", req_rdy, rsp_vld);
        end
        tick();
        req_vld = 4'b0010;
        mid();
        n_checks++;
        if (req_rdy !== 4'b0000) begin n_errors++; $display("FAIL bp_blocked: rdy=%b want 0000", req_rdy); end
        tick();
        mid();
        n_checks++;
        if (rsp_vld !== 4'b0110 || rsp_data[95:64] !== 32'd42 || req_rdy !== 4'b0000) begin
            n_errors++;
            $display("FAIL bp_slot2: vld=%b data=%0d rdy=%b want 0110/42/0000", rsp_vld, rsp_data[95:64], req_rdy);
        end
        tick();
        rsp_rdy = 4'b0010;
        mid();
        n_checks++;
        if (req_rdy !== 4'b0010 || add_ce !== 1'b1 || add_a !== 32'd1) begin
            n_errors++; $display("FAIL bp_drain_grant: rdy=%b ce=%b a=%0d want 0010/1/1", req_rdy, add_ce, add_a);
        end
        tick();
        req_vld = 4'b0000;
        rsp_rdy = 4'b1111;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_op();
        rsp_rdy      = 4'b0000;
        req_a[95:64] = 32'd3;
        req_b[95:64] = 32'd4;
        req_vld      = 4'b0100;
        mid();
        n_checks++;
        if (req_rdy !== 4'b0100) begin n_errors++; $display("FAIL rst_mid_issue: rdy=%b want 0100", req_rdy); end
        tick();
        req_vld = 4'b0000;
        ap_rst  = 1'b1;
        tick();
        ap_rst  = 1'b0;
        mid();
        n_checks++;
        if (rsp_vld !== 4'b0000 || rsp_data !== 128'd0) begin
            n_errors++; $display("FAIL rst_mid_flush: vld=%b data=%h want 0000/0", rsp_vld, rsp_data);
        end
        tick();
        mid();
        n_checks++;
        if (rsp_vld !== 4'b0000) begin n_errors++; $display("FAIL rst_mid_late: vld=%b want 0000", rsp_vld); end
        tick();
        req_vld = 4'b1111;
        mid();
        n_checks++;
        if (req_rdy !== 4'b0001) begin n_errors++; $display("FAIL rst_mid_first: rdy=%b want 0001", req_rdy); end
        tick();
        req_vld = 4'b0000;
    endtask

`ifdef ADD_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        mid();
        n_checks++;
        if (perf_ops !== 32'd0) begin n_errors++; $display("FAIL perf_reset: got %0d want 0", perf_ops); end
        tick();
        req_vld = 4'b0011;
        rsp_rdy = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        req_vld = 4'b0000;
        tick();
        tick();
        mid();
        n_checks++;
        if (perf_ops !== 32'd10) begin n_errors++; $display("FAIL perf_count: got %0d want 10", perf_ops); end
        tick();
        force dut.r_perf_ops = 32'hFFFF_FFFF;
        #1;
        release dut.r_perf_ops;
        req_vld = 4'b0001;
        tick();
        req_vld = 4'b0000;
        mid();
        n_checks++;
        if (perf_ops !== 32'd0) begin n_errors++; $display("FAIL perf_wrap: got %h want 00000000", perf_ops); end
        tick();
    endtask
`endif

    initial begin
        ap_rst  = 1'b1;
        req_vld = 4'b0000;
        rsp_rdy = 4'b0000;
        req_a   = 128'd0;
        req_b   = 128'd0;
        test_reset();
        test_single_op();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
`ifdef ADD_SCHED_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
